// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer
// Line-granularity write buffer that sits between the cache hierarchy's
// physical-memory port and physical memory. Dirty-line writebacks are parked
// in a small circular FIFO and answered in one cycle, so a following line fill
// reaches memory first. Buffered lines drain whenever the upstream port is
// idle, and reads that hit a buffered line are served straight from the buffer.
//
// Build option: define WB_COALESCE_EN to merge a write into an already
// buffered copy of the same line instead of enqueueing a second entry.
module pmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [255:0] mem_wdata,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata,
  output logic         wb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    PREAD,
    PWRITE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // FIFO bookkeeping
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic [DEPTH-1:0] r_valid;
  logic [26:0]      r_tag  [DEPTH];
  logic [255:0]     r_data [DEPTH];

  // Registered outputs
  logic [255:0] r_memRdata;
  logic         r_memResp;
  logic         r_pmemRead;
  logic         r_pmemWrite;
  logic [31:0]  r_pmemAddress;
  logic [255:0] r_pmemWdata;
  logic         r_wbEmpty;

  // Lookup and control strobes
  logic [26:0]      w_lineAddr;
  logic [PTR_W-1:0] w_scanIdx [DEPTH];
  logic             w_hit;
  logic [PTR_W-1:0] w_hitIdx;
  logic             w_full;
  logic             w_empty;
  logic             w_loadHit;
  logic             w_startRead;
  logic             w_capture;
  logic             w_enq;
  logic             w_coalesce;
  logic             w_startDrain;
  logic             w_pop;
  logic             w_unusedOffset;

  // The byte offset inside a line carries no meaning for a line buffer.
  assign w_unusedOffset = ^mem_address[4:0];

  assign w_lineAddr = mem_address[31:5];
  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);

  // Physical slot of the k-th oldest entry, walking from head toward tail.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_scanIdx[k] = r_head + PTR_W'(k);
    end
  end

  // Find the youngest valid entry whose tag matches the upstream line.
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[w_scanIdx[k]] && (r_tag[w_scanIdx[k]] == w_lineAddr)) begin
        w_hit    = 1'b1;
        w_hitIdx = w_scanIdx[k];
      end
    end
  end

  // Next-state and action decode; IDLE arbitrates upstream requests by priority.
  always_comb begin
    w_stateNext  = r_state;
    w_loadHit    = 1'b0;
    w_startRead  = 1'b0;
    w_capture    = 1'b0;
    w_enq        = 1'b0;
    w_coalesce   = 1'b0;
    w_startDrain = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read) begin
          if (w_hit) begin
            w_loadHit   = 1'b1;
            w_stateNext = RESP;
          end else begin
            w_startRead = 1'b1;
            w_stateNext = PREAD;
          end
        end else if (mem_write) begin
`ifdef WB_COALESCE_EN
          if (w_hit) begin
            w_coalesce  = 1'b1;
            w_stateNext = RESP;
          end else if (!w_full) begin
            w_enq       = 1'b1;
            w_stateNext = RESP;
          end else begin
            w_startDrain = 1'b1;
            w_stateNext  = PWRITE;
          end
`else
          if (!w_full) begin
            w_enq       = 1'b1;
            w_stateNext = RESP;
          end else begin
            w_startDrain = 1'b1;
            w_stateNext  = PWRITE;
          end
`endif
        end else if (!w_empty) begin
          w_startDrain = 1'b1;
          w_stateNext  = PWRITE;
        end
      end
      RESP: begin
        w_stateNext = IDLE;
      end
      PREAD: begin
        if (pmem_resp) begin
          w_capture   = 1'b1;
          w_stateNext = RESP;
        end
      end
      PWRITE: begin
        if (pmem_resp) begin
          w_pop       = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Occupancy after this cycle's enqueue or pop (never both in one cycle).
  always_comb begin
    w_countNext = r_count;
    if (w_enq) begin
      w_countNext = r_count + CNT_W'(1);
    end else if (w_pop) begin
      w_countNext = r_count - CNT_W'(1);
    end
  end

  // State, FIFO pointers, valid bits and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_valid       <= '0;
      r_memRdata    <= '0;
      r_memResp     <= 1'b0;
      r_pmemRead    <= 1'b0;
      r_pmemWrite   <= 1'b0;
      r_pmemAddress <= '0;
      r_pmemWdata   <= '0;
      r_wbEmpty     <= 1'b1;
    end else begin
      r_state     <= w_stateNext;
      r_count     <= w_countNext;
      r_wbEmpty   <= (w_countNext == '0);
      r_memResp   <= (w_stateNext == RESP);
      r_pmemRead  <= (w_stateNext == PREAD);
      r_pmemWrite <= (w_stateNext == PWRITE);
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_loadHit) begin
        r_memRdata <= r_data[w_hitIdx];
      end
      if (w_capture) begin
        r_memRdata <= pmem_rdata;
      end
      if (w_startRead) begin
        r_pmemAddress <= {w_lineAddr, 5'b00000};
      end
      if (w_startDrain) begin
        r_pmemAddress <= {r_tag[r_head], 5'b00000};
        r_pmemWdata   <= r_data[r_head];
      end
    end
  end

  // Entry payload; validity alone decides liveness, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_tag[r_tail]  <= w_lineAddr;
      r_data[r_tail] <= mem_wdata;
    end else if (w_coalesce) begin
      r_data[w_hitIdx] <= mem_wdata;
    end
  end

  assign mem_rdata    = r_memRdata;
  assign mem_resp     = r_memResp;
  assign pmem_read    = r_pmemRead;
  assign pmem_write   = r_pmemWrite;
  assign pmem_address = r_pmemAddress;
  assign pmem_wdata   = r_pmemWdata;
  assign wb_empty     = r_wbEmpty;

endmodule

// File: tb/tb_pmem_write_buffer.sv
// tb_pmem_write_buffer
// Directed scenarios followed by a randomized mix of line reads and writes.
// The bench plays physical memory itself and keeps a reference model of the
// buffer as an ordered queue of {line, data} plus a sparse memory image.
module tb_pmem_write_buffer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_address = '0;
  logic [255:0] mem_wdata = '0;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [255:0] pmem_rdata = '0;
  logic         wb_empty;

  pmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .wb_empty     (wb_empty)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [26:0]  tag;
    logic [255:0] data;
  } entry_t;

  entry_t       modelQ[$];
  logic [255:0] memModel [logic [31:0]];
  bit           evWrite[$];
  logic [31:0]  evAddr[$];
  logic [255:0] evData[$];

  int checks = 0;
  int errors = 0;
  bit memHold = 1'b0;
  bit reqActive = 1'b0;
  int memWait = 0;

  function automatic logic [255:0] memInit(input logic [31:0] line);
    return {8{line ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [255:0] memRead(input logic [31:0] addr);
    logic [31:0] line;
    line = {addr[31:5], 5'b00000};
    if (memModel.exists(line)) return memModel[line];
    return memInit(line);
  endfunction

  function automatic bit modelHas(input logic [31:0] addr);
    foreach (modelQ[i]) if (modelQ[i].tag == addr[31:5]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [255:0] modelRead(input logic [31:0] addr);
    for (int i = modelQ.size() - 1; i >= 0; i--) begin
      if (modelQ[i].tag == addr[31:5]) return modelQ[i].data;
    end
    return memRead(addr);
  endfunction

  function automatic void modelWrite(input logic [31:0] addr, input logic [255:0] data);
    entry_t e;
`ifdef WB_COALESCE_EN
    foreach (modelQ[i]) begin
      if (modelQ[i].tag == addr[31:5]) begin
        modelQ[i].data = data;
        return;
      end
    end
`endif
    e.tag  = addr[31:5];
    e.data = data;
    modelQ.push_back(e);
  endfunction

  function automatic bit evWriteAt(input int i);
    if (i < evWrite.size()) return evWrite[i];
    return 1'b0;
  endfunction

  function automatic logic [31:0] evAddrAt(input int i);
    if (i < evAddr.size()) return evAddr[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [255:0] evDataAt(input int i);
    if (i < evData.size()) return evData[i];
    return '1;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock step; afterwards act as physical memory for any open request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pmem_resp) begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      reqActive  = 1'b0;
    end else if (pmem_read || pmem_write) begin
      if (!reqActive) begin
        reqActive = 1'b1;
        memWait   = $urandom_range(0, 3);
        evWrite.push_back(pmem_write);
        evAddr.push_back(pmem_address);
        evData.push_back(pmem_wdata);
        checkOutput("pmemAddrAligned", pmem_address[4:0], 5'd0);
        if (pmem_read) checkOutput("readNotBuffered", modelHas(pmem_address), 1'b0);
      end
      if (!memHold) begin
        if (memWait == 0) begin
          if (pmem_read) begin
            pmem_rdata = memRead(pmem_address);
          end else begin
            checkOutput("drainHasEntry", modelQ.size() != 0, 1'b1);
            if (modelQ.size() != 0) begin
              checkOutput("drainAddr", pmem_address, {modelQ[0].tag, 5'b00000});
              checkOutput("drainData", pmem_wdata, modelQ[0].data);
              void'(modelQ.pop_front());
            end
            memModel[{pmem_address[31:5], 5'b00000}] = pmem_wdata;
          end
          pmem_resp = 1'b1;
        end else begin
          memWait--;
        end
      end
    end
  endtask

  task automatic driveReq(input bit isWrite, input logic [31:0] addr, input logic [255:0] wdata);
    mem_read    = !isWrite;
    mem_write   = isWrite;
    mem_address = addr;
    mem_wdata   = wdata;
  endtask

  task automatic waitResp(input bit isWrite, input logic [31:0] addr, input logic [255:0] wdata,
                          output logic [255:0] rdata, output int latency);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      tick();
      n++;
      got = mem_resp;
    end
    checkOutput("respArrived", got, 1'b1);
    latency   = n;
    rdata     = mem_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (got) begin
      if (isWrite) modelWrite(addr, wdata);
      else checkOutput("readData", rdata, modelRead(addr));
    end
  endtask

  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                               input logic [255:0] wdata,
                               output logic [255:0] rdata, output int latency);
    driveReq(isWrite, addr, wdata);
    waitResp(isWrite, addr, wdata, rdata, latency);
  endtask

  task automatic waitEmpty();
    int n;
    n = 0;
    while (!(wb_empty && !pmem_write && !pmem_read && !pmem_resp) && n < 400) begin
      tick();
      n++;
    end
    checkOutput("drainFinished", wb_empty, 1'b1);
    checkOutput("modelDrained", modelQ.size(), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "MemResp"}, mem_resp, 1'b0);
    checkOutput({tag, "PmemRead"}, pmem_read, 1'b0);
    checkOutput({tag, "PmemWrite"}, pmem_write, 1'b0);
    checkOutput({tag, "MemRdata"}, mem_rdata, '0);
    checkOutput({tag, "PmemAddress"}, pmem_address, 32'd0);
    checkOutput({tag, "PmemWdata"}, pmem_wdata, '0);
    checkOutput({tag, "WbEmpty"}, wb_empty, 1'b1);
  endtask

  // Directed scenarios, then random traffic, then the summary.
  initial begin
    logic [255:0] rd;
    logic [255:0] dataA;
    logic [255:0] dataB;
    logic [255:0] dataC;
    logic [255:0] dataD;
    logic [255:0] dataE;
    logic [255:0] wdata;
    logic [31:0]  addr;
    int           lat;
    int           base;
    bit           sawResp;
    bit           isWrite;

    dataA = {8{32'hAAAA_0001}};
    dataB = {8{32'hBBBB_0002}};
    dataC = {8{32'hCCCC_0003}};
    dataD = {8{32'hDDDD_0004}};
    dataE = {8{32'hEEEE_0005}};

    $display("[TB] reset");
    repeat (3) tick();
    checkResetState("reset");
    rst_n = 1'b1;
    tick();

    $display("[TB] write then miss-read");
    base = evAddr.size();
    applyStimulus(1'b1, 32'h0000_1000, dataA, rd, lat);
    checkOutput("writeLatency", lat, 1);
    checkOutput("wbEmptyAfterWrite", wb_empty, 1'b0);
    applyStimulus(1'b0, 32'h0000_2000, '0, rd, lat);
    checkOutput("missReadData", rd, memInit(32'h0000_2000));
    checkOutput("firstMemOpIsRead", evWriteAt(base), 1'b0);
    checkOutput("firstMemOpAddr", evAddrAt(base), 32'h0000_2000);
    checkOutput("opsBeforeDrain", evAddr.size() - base, 1);
    waitEmpty();
    checkOutput("drainIsWrite", evWriteAt(base + 1), 1'b1);
    checkOutput("drainAddrA", evAddrAt(base + 1), 32'h0000_1000);
    checkOutput("drainDataA", evDataAt(base + 1), dataA);

    $display("[TB] read hit");
    base = evAddr.size();
    applyStimulus(1'b1, 32'h0000_3040, dataB, rd, lat);
    // The read is driven during the write's RESP cycle, so it is sampled one
    // cycle later and answered the cycle after that.
    applyStimulus(1'b0, 32'h0000_3044, '0, rd, lat);
    checkOutput("hitData", rd, dataB);
    checkOutput("hitLatency", lat, 2);
    checkOutput("hitNoMemOp", evAddr.size() - base, 0);
    waitEmpty();

    $display("[TB] full buffer");
    base = evAddr.size();
    memHold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'h0000_6000 + 32'(i * 32), {8{32'(i + 32'h600)}}, rd, lat);
    end
    driveReq(1'b1, 32'h0000_6080, {8{32'h0000_0604}});
    sawResp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sawResp = sawResp | mem_resp;
    end
    checkOutput("fullWriteStalled", sawResp, 1'b0);
    checkOutput("fullDrainActive", pmem_write, 1'b1);
    checkOutput("fullDrainHead", pmem_address, 32'h0000_6000);
    memHold = 1'b0;
    waitResp(1'b1, 32'h0000_6080, {8{32'h0000_0604}}, rd, lat);
    waitEmpty();
    for (int i = 0; i <= DEPTH; i++) begin
      checkOutput($sformatf("fifoOrderAddr%0d", i), evAddrAt(base + i), 32'h0000_6000 + 32'(i * 32));
      checkOutput($sformatf("fifoOrderWrite%0d", i), evWriteAt(base + i), 1'b1);
    end

    $display("[TB] same-line writes");
    base = evAddr.size();
    applyStimulus(1'b1, 32'h0000_4000, dataC, rd, lat);
    applyStimulus(1'b1, 32'h0000_4000, dataD, rd, lat);
    applyStimulus(1'b0, 32'h0000_4000, '0, rd, lat);
    checkOutput("sameLineReadBack", rd, dataD);
    waitEmpty();
`ifdef WB_COALESCE_EN
    checkOutput("coalesceDrainCount", evAddr.size() - base, 1);
    checkOutput("coalesceDrainData", evDataAt(base), dataD);
`else
    checkOutput("sameLineDrainCount", evAddr.size() - base, 2);
    checkOutput("sameLineFirstData", evDataAt(base), dataC);
    checkOutput("sameLineSecondData", evDataAt(base + 1), dataD);
`endif

    $display("[TB] reset mid-drain");
    memHold = 1'b1;
    applyStimulus(1'b1, 32'h0000_5000, dataE, rd, lat);
    for (int i = 0; i < 10 && !pmem_write; i++) tick();
    checkOutput("midDrainWrite", pmem_write, 1'b1);
    rst_n = 1'b0;
    tick();
    checkResetState("midReset");
    rst_n     = 1'b1;
    reqActive = 1'b0;
    memHold   = 1'b0;
    modelQ.delete();
    tick();
    base = evAddr.size();
    applyStimulus(1'b0, 32'h0000_5008, '0, rd, lat);
    checkOutput("postResetReadIssued", evWriteAt(base), 1'b0);
    checkOutput("postResetReadAddr", evAddrAt(base), 32'h0000_5000);
    checkOutput("postResetReadData", rd, memInit(32'h0000_5000));
    waitEmpty();

    $display("[TB] random traffic");
    for (int k = 0; k < 80; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      isWrite = 1'($urandom_range(0, 1));
      addr    = 32'h0000_8000 | 32'($urandom_range(0, 5) << 5) | 32'($urandom_range(0, 31));
      for (int w = 0; w < 8; w++) wdata[w*32 +: 32] = $urandom();
      applyStimulus(isWrite, addr, wdata, rd, lat);
    end
    waitEmpty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_write_buffer.md
# pmem_write_buffer

Line-granularity write buffer between `cache_hierarchy`'s physical-memory port and physical memory. Dirty-line writebacks are absorbed in one cycle, so the cache's line fill is issued to memory ahead of them. Buffered lines drain to memory when the upstream port is idle. Reads that hit a buffered line are served from the buffer.

## Interface
- `DEPTH`, default 4: number of 256-bit line entries; power of two, ≥ 2.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `mem_read` in 1: upstream line read; held high until `mem_resp`.
- `mem_write` in 1: upstream line write; held high until `mem_resp`.
- `mem_address` in 32: upstream byte address; bits [4:0] ignored.
- `mem_wdata` in 256: upstream write line.
- `mem_rdata` out 256: read line; valid while `mem_resp` = 1.
- `mem_resp` out 1: one-cycle completion pulse.
- `pmem_read` out 1: memory read request; held until `pmem_resp`.
- `pmem_write` out 1: memory write request; held until `pmem_resp`.
- `pmem_address` out 32: line-aligned memory address; bits [4:0] are always 0.
- `pmem_wdata` out 256: memory write line.
- `pmem_resp` in 1: memory completion; `pmem_rdata` is valid in the same cycle.
- `pmem_rdata` in 256: memory read line.
- `wb_empty` out 1: high when no entry is valid.

## Operation
- Storage is a circular FIFO of `DEPTH` entries: {valid, tag[31:5], data[255:0]}, with head/tail pointers and a count.
- Line match means tag equals `mem_address[31:5]`.
- FSM states: IDLE, RESP, PREAD, PWRITE. All outputs are registered.
- In IDLE, requests are handled in this priority order:
  1. **Read hit**: load `mem_rdata` from the matching entry, then go to RESP.
  2. **Read miss**: latch the address, go to PREAD, and assert `pmem_read`.
  3. **Write, buffer not full**: enqueue at the tail (or coalesce, see Configuration), then go to RESP.
  4. **Write, buffer full**: go to PWRITE to drain the head entry. The write is accepted from IDLE after that drain completes.
  5. **No request, buffer non-empty**: go to PWRITE with the head entry's tag and data.
- RESP: `mem_resp` = 1 for exactly one cycle, then return to IDLE.
- PREAD: hold `pmem_read`. On `pmem_resp`, capture `pmem_rdata` into `mem_rdata`, drop `pmem_read`, and go to RESP.
- PWRITE: hold `pmem_write`. On `pmem_resp`, pop the head (clear valid, advance head), drop `pmem_write`, and return to IDLE.
- Upstream requests that arrive during PWRITE wait; an in-flight memory transaction is never aborted.
- A read never misses on a buffered line, so memory is never read stale.
- `wb_empty` = (count == 0), registered.
- The pointers wrap modulo `DEPTH`. Count runs from 0 to `DEPTH`; full means count == `DEPTH`.
- Reset: all entries invalid, pointers and count 0, state IDLE.
  - `mem_resp`, `pmem_read`, `pmem_write` = 0; `mem_rdata`, `pmem_address`, `pmem_wdata` = 0; `wb_empty` = 1.
  - Reset mid-transaction discards the transaction and all buffered data.

## Timing
- Request sampled in IDLE at cycle N:
  - Read hit or accepted write: `mem_resp` at N+1.
  - Read miss: `pmem_read` from N+1. If `pmem_resp` arrives at cycle M, `mem_resp` follows at M+1.
- Drain start: the first IDLE cycle with no upstream request raises `pmem_write` on the next cycle.
- A request that arrives while a drain is in flight is evaluated in the IDLE cycle after that drain's `pmem_resp`.
- Upstream requests are deasserted in the cycle after `mem_resp`. A request still high in the IDLE cycle following RESP is treated as new.

## Configuration
- `WB_COALESCE_EN` defined:
  - A write whose line matches a valid entry overwrites that entry's data in place; count is unchanged.
  - This applies even when the buffer is full, so a matching write never waits for a drain.
  - The head entry is never mid-drain in IDLE, so coalescing is always safe.
- `WB_COALESCE_EN` undefined:
  - Every write enqueues a new entry.
  - A read hit returns the data of the youngest matching entry, meaning the one nearest the tail.

## Test plan
- **Write then miss-read:** write 0x1000/data A, then read 0x2000.
  - `mem_resp` for the write one cycle after sampling.
  - Then `pmem_read` @0x2000 before any `pmem_write`.
  - Then drain `pmem_write` @0x1000 with data A; `wb_empty` returns to 1.
- **Read hit:** write 0x3040 with data B, then read 0x3044 immediately.
  - `mem_rdata` = B with `mem_resp` one cycle after sampling.
  - No `pmem_read` is issued.
- **Full buffer (DEPTH = 4):** hold `pmem_resp` low, then issue 5 writes to distinct lines.
  - The 5th write waits until the first line's `pmem_write` completes.
  - The 5th write is then accepted, and the remaining lines drain in FIFO order.
- **Same-line writes:** write 0x4000 with C, then with D.
  - Coalesce on: one entry, one `pmem_write` with data D.
  - Coalesce off: two `pmem_write` transactions (C, then D), and a read of 0x4000 between them returns D.
- **Reset mid-drain:** pull `rst_n` low while `pmem_write` is high.
  - Next cycle all outputs are at their reset values and `wb_empty` = 1.
  - A subsequent read of that line goes to `pmem_read`.
